// File: rtl/edge_io_pkg.sv
// Shared types and sizing helpers for the edge-detect memory I/O engine.
package edge_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        PAD,
        DONE
    } state_e;

    localparam int RD_MAX_DEF = 20;
    localparam int WR_MAX_DEF = 10;

    // Bits needed to hold any length from 0 up to and including max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/edge_window_pad.sv
// RD_MAX-pixel staging window: single-slot load per cycle, plus a one-cycle
// border replication that fills the unread slots from the nearest real pixel.
module edge_window_pad
    import edge_io_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int RD_MAX = RD_MAX_DEF,
    parameter int LEN_W  = len_w(RD_MAX)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    load_en,
    input  logic [LEN_W-1:0]        load_slot,
    input  logic [PIX_W-1:0]        load_data,
    input  logic                    pad_en,
    input  logic                    pad_left,
    input  logic [LEN_W-1:0]        len,
    output logic [RD_MAX*PIX_W-1:0] stage_nxt
);

    logic [RD_MAX*PIX_W-1:0] stage_q;
    logic [RD_MAX*PIX_W-1:0] stage_d;
    logic [PIX_W-1:0]        fill;

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stage_d = stage_q;
        fill    = '0;
        if (load_en) begin
            stage_d[int'(load_slot)*PIX_W +: PIX_W] = load_data;
        end
        if (pad_en) begin
            fill = pad_left ? stage_q[(RD_MAX - int'(len))*PIX_W +: PIX_W]
                            : stage_q[(int'(len) - 1)*PIX_W +: PIX_W];
            for (int i = 0; i < RD_MAX; i++) begin
                if (pad_left ? (i < RD_MAX - int'(len)) : (i >= int'(len))) begin
                    stage_d[i*PIX_W +: PIX_W] = fill;
                end
            end
        end
    end

    // NOTE: the window is only RD_MAX pixels of flops, so it is reset like any
    // other register; a reset mid-burst must not leave stale pixels behind.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // The controller captures the post-edge window on the edge entering DONE.
    assign stage_nxt = stage_d;

endmodule

// File: rtl/edge_io_burst_ctrl.sv
// Burst controller: drains a write block to memory, then fetches and
// border-pads the next read window, one pixel per mem_ack handshake.
module edge_io_burst_ctrl
    import edge_io_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 8,
    parameter int RD_MAX = RD_MAX_DEF,
    parameter int WR_MAX = WR_MAX_DEF,
    parameter int LEN_W  = len_w((RD_MAX > WR_MAX) ? RD_MAX : WR_MAX)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    req_start,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [LEN_W-1:0]        rd_len,
    input  logic                    pad_left,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LEN_W-1:0]        wr_len,
    input  logic [WR_MAX*PIX_W-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    output logic [RD_MAX*PIX_W-1:0] rd_data,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [PIX_W-1:0]        mem_wdata,
    input  logic [PIX_W-1:0]        mem_rdata,
    input  logic                    mem_ack
);

    localparam logic [LEN_W-1:0] RD_MAX_L = LEN_W'(RD_MAX);
    localparam logic [LEN_W-1:0] WR_MAX_L = LEN_W'(WR_MAX);

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]        rd_len_q, rd_len_d;
    logic [LEN_W-1:0]        wr_len_q, wr_len_d;
    logic                    pad_left_q, pad_left_d;
    logic [WR_MAX*PIX_W-1:0] wr_buf_q, wr_buf_d;
    logic                    err_len_q, err_len_d;
    logic [RD_MAX*PIX_W-1:0] rd_data_q, rd_data_d;

    logic [LEN_W-1:0]        rd_len_c, wr_len_c;
    logic                    load_en, pad_en;
    logic [LEN_W-1:0]        load_slot;
    logic [RD_MAX*PIX_W-1:0] stage_nxt;

    edge_window_pad #(
        .PIX_W  (PIX_W),
        .RD_MAX (RD_MAX),
        .LEN_W  (LEN_W)
    ) u_window (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_en   (load_en),
        .load_slot (load_slot),
        .load_data (mem_rdata),
        .pad_en    (pad_en),
        .pad_left  (pad_left_q),
        .len       (rd_len_q),
        .stage_nxt (stage_nxt)
    );

    assign rd_len_c = (rd_len > RD_MAX_L) ? RD_MAX_L : rd_len;
    assign wr_len_c = (wr_len > WR_MAX_L) ? WR_MAX_L : wr_len;
    // Left padding right-aligns the fetched pixels so the replicated border sits in the low slots.
    assign load_slot = pad_left_q ? (cnt_q + RD_MAX_L - rd_len_q) : cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        rd_len_d   = rd_len_q;
        wr_len_d   = wr_len_q;
        pad_left_d = pad_left_q;
        wr_buf_d   = wr_buf_q;
        err_len_d  = err_len_q;
        rd_data_d  = rd_data_q;
        load_en    = 1'b0;
        pad_en     = 1'b0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (req_start) begin
                    rd_addr_d  = rd_addr;
                    wr_addr_d  = wr_addr;
                    rd_len_d   = rd_len_c;
                    wr_len_d   = wr_len_c;
                    pad_left_d = pad_left;
                    wr_buf_d   = wr_data;
                    err_len_d  = (rd_len > RD_MAX_L) || (wr_len > WR_MAX_L);
                    cnt_d      = '0;
                    state_d    = (wr_len_c != '0) ? WRITE
                               : (rd_len_c != '0) ? READ : DONE;
                end
            end
            WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q + ADDR_W'(cnt_q);
                mem_wdata = wr_buf_q[int'(cnt_q)*PIX_W +: PIX_W];
                if (mem_ack) begin
                    if (cnt_q == wr_len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (rd_len_q != '0) ? READ : DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = rd_addr_q + ADDR_W'(cnt_q);
                if (mem_ack) begin
                    load_en = 1'b1;
                    if (cnt_q == rd_len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (rd_len_q < RD_MAX_L) ? PAD : DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            PAD: begin
                pad_en  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only a burst that actually fetched pixels updates the visible window.
        if (state_d == DONE && (state_q == READ || state_q == PAD)) begin
            rd_data_d = stage_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_len_q   <= '0;
            pad_left_q <= 1'b0;
            wr_buf_q   <= '0;
            err_len_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_len_q   <= rd_len_d;
            wr_len_q   <= wr_len_d;
            pad_left_q <= pad_left_d;
            wr_buf_q   <= wr_buf_d;
            err_len_q  <= err_len_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err_len = err_len_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_edge_io_burst_ctrl.sv
// Directed bench for edge_io_burst_ctrl: simple memory model, write/read
// monitors, and hand-computed windows and done latencies.
module tb_edge_io_burst_ctrl;

    localparam int ADDR_W = 32;
    localparam int PIX_W  = 8;
    localparam int RD_MAX = 20;
    localparam int WR_MAX = 10;
    localparam int LEN_W  = 5;

    logic                    clk;
    logic                    n_rst;
    logic                    req_start;
    logic [ADDR_W-1:0]       rd_addr;
    logic [LEN_W-1:0]        rd_len;
    logic                    pad_left;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LEN_W-1:0]        wr_len;
    logic [WR_MAX*PIX_W-1:0] wr_data;
    logic                    busy;
    logic                    done;
    logic                    err_len;
    logic [RD_MAX*PIX_W-1:0] rd_data;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [PIX_W-1:0]        mem_wdata;
    logic [PIX_W-1:0]        mem_rdata;
    logic                    mem_ack;

    logic [PIX_W-1:0]  mem_img [256];
    logic [ADDR_W-1:0] wlog_addr [$];
    logic [PIX_W-1:0]  wlog_data [$];
    logic [ADDR_W-1:0] rlog_addr [$];
    int                rd_strobe_cnt = 0;
    int                done_cnt      = 0;
    bit                overlap_seen  = 1'b0;
    bit                ack_toggle    = 1'b0;

    int checks = 0;
    int errors = 0;

    edge_io_burst_ctrl #(
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .RD_MAX (RD_MAX),
        .WR_MAX (WR_MAX),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_start (req_start),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .pad_left  (pad_left),
        .wr_addr   (wr_addr),
        .wr_len    (wr_len),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_img[mem_addr[7:0]];

    always @(posedge clk) begin
        if (n_rst && mem_wr && mem_ack) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
        if (n_rst && mem_rd && mem_ack) rlog_addr.push_back(mem_addr);
        if (mem_rd) rd_strobe_cnt++;
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap_seen = 1'b1;
    end

    task automatic wait_done(input int start_n, output int n);
        n = start_n;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            if (ack_toggle) mem_ack = ~mem_ack;
            n++;
        end
        if (done !== 1'b1) begin
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
            errors++;
            n = -1;
        end
        checks++;
    endtask

    task automatic run_req(input logic [ADDR_W-1:0] ra, input logic [LEN_W-1:0] rl,
                           input logic pl, input logic [ADDR_W-1:0] wa,
                           input logic [LEN_W-1:0] wl, input logic [WR_MAX*PIX_W-1:0] wd,
                           output int n);
        @(posedge clk);
        #1;
        rd_addr   = ra;
        rd_len    = rl;
        pad_left  = pl;
        wr_addr   = wa;
        wr_len    = wl;
        wr_data   = wd;
        req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        if (ack_toggle) mem_ack = ~mem_ack;
        wait_done(0, n);
    endtask

    task automatic test_reset();
        if ({busy, done, err_len, mem_rd, mem_wr} !== 5'b0 || rd_data !== '0 || mem_addr !== '0) begin
            $display("FAIL reset_outputs: busy=%b done=%b err=%b rd=%b wr=%b addr=%h rd_data=%h, required all 0",
                     busy, done, err_len, mem_rd, mem_wr, mem_addr, rd_data);
            errors++;
        end
        checks++;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
            errors++;
        end
        checks++;
    endtask

    task automatic test_full_burst();
        logic [WR_MAX*PIX_W-1:0] wd;
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n, w0;
        for (int k = 0; k < WR_MAX; k++) wd[k*PIX_W +: PIX_W] = 8'hC0 + 8'(k);
        for (int i = 0; i < RD_MAX; i++) exp_v[i*PIX_W +: PIX_W] = 8'(i);
        w0 = wlog_addr.size();
        run_req(32'h0, 5'd20, 1'b0, 32'h100, 5'd10, wd, n);
        if (n !== 30) begin
            $display("FAIL full_latency: N=%0d, required 30", n);
            errors++;
        end
        checks++;
        if (wlog_addr.size() - w0 !== 10) begin
            $display("FAIL full_write_count: %0d writes, required 10", wlog_addr.size() - w0);
            errors++;
        end else begin
            for (int k = 0; k < WR_MAX; k++) begin
                if (wlog_addr[w0+k] !== 32'h100 + 32'(k) || wlog_data[w0+k] !== 8'hC0 + 8'(k)) begin
                    $display("FAIL full_write_%0d: addr=%h data=%h, required %h %h", k,
                             wlog_addr[w0+k], wlog_data[w0+k], 32'h100 + 32'(k), 8'hC0 + 8'(k));
                    errors++;
                end
                checks++;
            end
        end
        checks++;
        if (rd_data !== exp_v) begin
            $display("FAIL full_rd_data: got %h, required %h", rd_data, exp_v);
            errors++;
        end
        checks++;
        if (err_len !== 1'b0) begin
            $display("FAIL full_err_len: got %b, required 0", err_len);
            errors++;
        end
        checks++;
    endtask

    task automatic test_pad(input logic pl);
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n;
        for (int i = 0; i < RD_MAX; i++) begin
            if (pl) exp_v[i*PIX_W +: PIX_W] = (i < 15) ? 8'd7 : 8'(i - 8);
            else    exp_v[i*PIX_W +: PIX_W] = (i < 5) ? 8'(7 + i) : 8'd11;
        end
        run_req(32'h80, 5'd5, pl, 32'h0, 5'd0, '0, n);
        if (n !== 6) begin
            $display("FAIL pad%0d_latency: N=%0d, required 6", pl, n);
            errors++;
        end
        checks++;
        if (rd_data !== exp_v) begin
            $display("FAIL pad%0d_rd_data: got %h, required %h", pl, rd_data, exp_v);
            errors++;
        end
        checks++;
    endtask

    task automatic test_ack_wait();
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n, r0, s0;
        for (int i = 0; i < RD_MAX; i++) exp_v[i*PIX_W +: PIX_W] = (i < 4) ? 8'hA0 + 8'(i) : 8'hA3;
        r0 = rlog_addr.size();
        s0 = rd_strobe_cnt;
        ack_toggle = 1'b1;
        run_req(32'h90, 5'd4, 1'b0, 32'h0, 5'd0, '0, n);
        ack_toggle = 1'b0;
        mem_ack = 1'b1;
        if (n !== 9) begin
            $display("FAIL ack_wait_latency: N=%0d, required 9", n);
            errors++;
        end
        checks++;
        if (rd_strobe_cnt - s0 !== 8) begin
            $display("FAIL ack_wait_strobe_hold: mem_rd high %0d cycles, required 8", rd_strobe_cnt - s0);
            errors++;
        end
        checks++;
        if (rlog_addr.size() - r0 !== 4) begin
            $display("FAIL ack_wait_read_count: %0d reads, required 4", rlog_addr.size() - r0);
            errors++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rlog_addr[r0+k] !== 32'h90 + 32'(k)) begin
                    $display("FAIL ack_wait_addr_%0d: got %h, required %h", k, rlog_addr[r0+k], 32'h90 + 32'(k));
                    errors++;
                end
                checks++;
            end
        end
        checks++;
        if (rd_data !== exp_v) begin
            $display("FAIL ack_wait_rd_data: got %h, required %h", rd_data, exp_v);
            errors++;
        end
        checks++;
    endtask

    task automatic test_busy_ignore();
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n, w0;
        for (int i = 0; i < RD_MAX; i++) exp_v[i*PIX_W +: PIX_W] = (i == 0) ? 8'd0 : 8'd1;
        w0 = wlog_addr.size();
        @(posedge clk);
        #1;
        rd_addr = 32'h0; rd_len = 5'd2; pad_left = 1'b0;
        wr_addr = 32'h0; wr_len = 5'd0; req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        @(posedge clk);
        #1;
        wr_addr = 32'h200; wr_len = 5'd3; req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        wait_done(2, n);
        if (n !== 3) begin
            $display("FAIL busy_ignore_latency: N=%0d, required 3", n);
            errors++;
        end
        checks++;
        if (wlog_addr.size() - w0 !== 0) begin
            $display("FAIL busy_ignore_writes: %0d writes, required 0", wlog_addr.size() - w0);
            errors++;
        end
        checks++;
        if (rd_data !== exp_v) begin
            $display("FAIL busy_ignore_rd_data: got %h, required %h", rd_data, exp_v);
            errors++;
        end
        checks++;
        @(posedge clk);
        #1;
        if (busy !== 1'b0) begin
            $display("FAIL busy_ignore_idle: busy=%b, required 0", busy);
            errors++;
        end
        checks++;
    endtask

    task automatic test_clamp_and_zero();
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n, r0;
        for (int i = 0; i < RD_MAX; i++) exp_v[i*PIX_W +: PIX_W] = 8'(i);
        r0 = rlog_addr.size();
        run_req(32'h0, 5'd25, 1'b0, 32'h0, 5'd0, '0, n);
        if (n !== 20 || rlog_addr.size() - r0 !== 20) begin
            $display("FAIL clamp_reads: N=%0d reads=%0d, required 20 20", n, rlog_addr.size() - r0);
            errors++;
        end
        checks++;
        if (rd_data !== exp_v) begin
            $display("FAIL clamp_rd_data: got %h, required %h", rd_data, exp_v);
            errors++;
        end
        checks++;
        repeat (3) @(posedge clk);
        #1;
        if (err_len !== 1'b1) begin
            $display("FAIL clamp_err_sticky: got %b, required 1", err_len);
            errors++;
        end
        checks++;
        run_req(32'h80, 5'd0, 1'b1, 32'h0, 5'd0, '0, n);
        if (n !== 0) begin
            $display("FAIL zero_latency: N=%0d, required 0", n);
            errors++;
        end
        checks++;
        if (rd_data !== exp_v || err_len !== 1'b0) begin
            $display("FAIL zero_hold: rd_data=%h err=%b, required %h 0", rd_data, err_len, exp_v);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [WR_MAX*PIX_W-1:0] wd;
        logic [RD_MAX*PIX_W-1:0] exp_v;
        int n, w0, d0;
        for (int k = 0; k < WR_MAX; k++) wd[k*PIX_W +: PIX_W] = 8'hC0 + 8'(k);
        for (int i = 0; i < RD_MAX; i++) exp_v[i*PIX_W +: PIX_W] = (i < 15) ? 8'd7 : 8'(i - 8);
        w0 = wlog_addr.size();
        @(posedge clk);
        #1;
        rd_addr = 32'h0; rd_len = 5'd4; pad_left = 1'b0;
        wr_addr = 32'h300; wr_len = 5'd10; wr_data = wd; req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h303 || mem_wdata !== 8'hC3) begin
            $display("FAIL mid_pixel3: wr=%b addr=%h data=%h, required 1 00000303 c3", mem_wr, mem_addr, mem_wdata);
            errors++;
        end
        checks++;
        d0 = done_cnt;
        #2;
        n_rst = 1'b0;
        #1;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || rd_data !== '0) begin
            $display("FAIL mid_async_abort: wr=%b busy=%b rd_data=%h, required 0 0 0", mem_wr, busy, rd_data);
            errors++;
        end
        checks++;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (done_cnt !== d0 || wlog_addr.size() - w0 !== 3) begin
            $display("FAIL mid_no_done: done pulses=%0d writes=%0d, required 0 3", done_cnt - d0, wlog_addr.size() - w0);
            errors++;
        end
        checks++;
        run_req(32'h80, 5'd5, 1'b1, 32'h0, 5'd0, '0, n);
        if (n !== 6 || rd_data !== exp_v) begin
            $display("FAIL mid_recover: N=%0d rd_data=%h, required 6 %h", n, rd_data, exp_v);
            errors++;
        end
        checks++;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_img[a] = 8'hEE;
        for (int a = 0; a < 20; a++)  mem_img[a] = 8'(a);
        for (int a = 0; a < 5; a++)   mem_img[8'h80 + a] = 8'(7 + a);
        for (int a = 0; a < 4; a++)   mem_img[8'h90 + a] = 8'hA0 + 8'(a);
        n_rst = 1'b0; req_start = 1'b0; mem_ack = 1'b1;
        rd_addr = '0; rd_len = '0; pad_left = 1'b0;
        wr_addr = '0; wr_len = '0; wr_data = '0;
        #12;
        test_reset();
        test_full_burst();
        test_pad(1'b1);
        test_pad(1'b0);
        test_ack_wait();
        test_busy_ignore();
        test_clamp_and_zero();
        test_reset_mid();
        if (overlap_seen !== 1'b0) begin
            $display("FAIL strobe_exclusive: mem_rd and mem_wr seen high together, required never");
            errors++;
        end
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
